// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder/subtractor that processes CHUNK bits per
// clock over WIDTH/CHUNK cycles, LSB chunk first, with a start/busy/done
// handshake.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset (overrides start)
//   start    request an operation; sampled only when not busy
//   sub      0 = A+B, 1 = A-B; sampled with start
//   A, B     WIDTH-bit operands; sampled with start
//   busy     high while the operation is in progress
//   done     one-cycle pulse; Sum/Carry/Overflow are valid
//   Sum      registered WIDTH-bit result, held until the next completion
//   Carry    carry out of the MSB (for subtraction: 1 = no borrow)
//   Overflow two's-complement signed overflow
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             Overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_opA;
    logic [WIDTH-1:0] r_opB;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic [CHUNK-1:0] w_a;
    logic [CHUNK-1:0] w_b;
    logic [CHUNK-1:0] w_s;
    logic             w_c;
    logic             w_last;
    logic             w_cin_msb;
    logic [WIDTH-1:0] w_res_next;

    // Operands and result are shift registers: the active chunk is always
    // the low CHUNK bits of the operands, and each new result chunk enters
    // at the top so that after NCHUNK steps the LSB chunk has reached bit 0.
    always_comb begin
        w_a        = r_opA[CHUNK-1:0];
        w_b        = r_opB[CHUNK-1:0];
        {w_c, w_s} = {1'b0, w_a} + {1'b0, w_b} + (CHUNK+1)'(r_carry);
        w_res_next = WIDTH'({w_s, r_res} >> CHUNK);
        w_last     = (r_cnt == CW'(NCHUNK - 1));
        // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
        w_cin_msb  = w_a[CHUNK-1] ^ w_b[CHUNK-1] ^ w_s[CHUNK-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = start ? S_RUN : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_opA    <= '0;
            r_opB    <= '0;
            r_res    <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            Sum      <= '0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_opA   <= A;
                        r_opB   <= sub ? ~B : B;
                        r_carry <= sub;
                        r_cnt   <= '0;
                        r_res   <= '0;
                    end
                end
                S_RUN: begin
                    r_opA   <= r_opA >> CHUNK;
                    r_opB   <= r_opB >> CHUNK;
                    r_res   <= w_res_next;
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        Sum      <= w_res_next;
                        Carry    <= w_c;
                        Overflow <= w_cin_msb ^ w_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
